// File: rtl/tod_pkg.sv
// Shared types and constants for the time-of-week sequencer.
// Field widths, default terminal counts, command codes and FSM states.
package tod_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int DAY_W = 3;

    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 59;
    localparam int HR_MAX_DEF  = 23;
    localparam int DAY_MAX_DEF = 6;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_CLEAR = 2'd3
    } tod_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_APPLY = 2'd2
    } tod_state_e;

    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [MIN_W-1:0] min;
        logic [HR_W-1:0]  hr;
        logic [DAY_W-1:0] day;
    } tod_time_t;

endpackage

// File: rtl/tod_wrap_cnt.sv
// Enable-driven wrap counter stage with registered carry-out.
// Priority: reset, clear, load, then enable.
module tod_wrap_cnt #(
    parameter int             W   = 6,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt,
    output logic         term,
    output logic         co
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         co_q, co_d;

    assign term = (cnt_q == MAX);
    assign cnt  = cnt_q;
    assign co   = co_q;

    // Next count and wrap carry
    always_comb begin
        cnt_d = cnt_q;
        co_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (en) begin
            if (term) begin
                cnt_d = '0;
                co_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count and carry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            co_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            co_q  <= co_d;
        end
    end

endmodule

// File: rtl/tod_week_sequencer.sv
// Time-of-week sequencer: FSM, command handshake, range checks,
// tick gating into the sec/min/hr/day cascade and alarm compare.
module tod_week_sequencer
    import tod_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int HR_MAX  = HR_MAX_DEF,
    parameter int DAY_MAX = DAY_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [SEC_W-1:0] ld_sec,
    input  logic [MIN_W-1:0] ld_min,
    input  logic [HR_W-1:0]  ld_hr,
    input  logic [DAY_W-1:0] ld_day,
    input  logic             alm_en,
    input  logic [HR_W-1:0]  alm_hr,
    input  logic [MIN_W-1:0] alm_min,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [HR_W-1:0]  hr,
    output logic [DAY_W-1:0] day,
    output logic             running,
    output logic             min_co,
    output logic             hr_co,
    output logic             day_co,
    output logic             week_co,
    output logic             alarm,
    output logic             cmd_err
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_RUN   = 2'(ST_RUN);
    localparam logic [1:0] S_APPLY = 2'(ST_APPLY);

    localparam logic [SEC_W-1:0] SEC_M = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_M = MIN_W'(MIN_MAX);
    localparam logic [HR_W-1:0]  HR_M  = HR_W'(HR_MAX);
    localparam logic [DAY_W-1:0] DAY_M = DAY_W'(DAY_MAX);

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q, ret_d;
    tod_time_t  ld_q, ld_d;
    logic       err_q, err_d;
    logic       alarm_q, alarm_d;

    logic accept, ld_ok, clr, apply;
    logic tick_en, en_sec, en_min, en_hr, en_day;
    logic sec_term, min_term, hr_term, day_term;
    logic [MIN_W-1:0] nxt_min;
    logic [HR_W-1:0]  nxt_hr;

    assign cmd_ready = (state_q != S_APPLY);
    assign accept    = cmd_valid & cmd_ready;
    assign running   = (state_q == S_RUN);
    assign cmd_err   = err_q;
    assign alarm     = alarm_q;

    assign ld_ok = (ld_sec <= SEC_M) && (ld_min <= MIN_M) &&
                   (ld_hr  <= HR_M)  && (ld_day <= DAY_M);

    // An accepted command always wins over a same-cycle tick
    assign tick_en = tick & (state_q == S_RUN) & ~accept;
    assign en_sec  = tick_en;
    assign en_min  = en_sec & sec_term;
    assign en_hr   = en_min & min_term;
    assign en_day  = en_hr & hr_term;

    // FSM, command decode and LOAD staging
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        ld_d    = ld_q;
        err_d   = 1'b0;
        clr     = 1'b0;
        apply   = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    unique case (tod_cmd_e'(cmd_op))
                        CMD_START: state_d = S_RUN;
                        CMD_STOP:  state_d = S_IDLE;
                        CMD_CLEAR: clr = 1'b1;
                        CMD_LOAD: begin
                            if (ld_ok) begin
                                ret_d   = state_q;
                                state_d = S_APPLY;
                                ld_d    = '{sec: ld_sec, min: ld_min,
                                            hr: ld_hr, day: ld_day};
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_APPLY: begin
                apply   = 1'b1;
                state_d = ret_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Alarm looks at the minute/hour values this tick will produce
    always_comb begin
        nxt_min = min_term ? '0 : min + 1'b1;
        nxt_hr  = hr;
        if (en_hr) begin
            nxt_hr = hr_term ? '0 : hr + 1'b1;
        end
        alarm_d = alm_en & en_min &
                  (nxt_min == alm_min) & (nxt_hr == alm_hr);
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            ld_q    <= '0;
            err_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            alarm_q <= alarm_d;
        end
    end

    tod_wrap_cnt #(.W(SEC_W), .MAX(SEC_M)) u_sec (
        .clk(clk), .rst(rst), .en(en_sec), .clr(clr), .ld(apply),
        .ld_val(ld_q.sec), .cnt(sec), .term(sec_term), .co(min_co)
    );

    tod_wrap_cnt #(.W(MIN_W), .MAX(MIN_M)) u_min (
        .clk(clk), .rst(rst), .en(en_min), .clr(clr), .ld(apply),
        .ld_val(ld_q.min), .cnt(min), .term(min_term), .co(hr_co)
    );

    tod_wrap_cnt #(.W(HR_W), .MAX(HR_M)) u_hr (
        .clk(clk), .rst(rst), .en(en_hr), .clr(clr), .ld(apply),
        .ld_val(ld_q.hr), .cnt(hr), .term(hr_term), .co(day_co)
    );

    tod_wrap_cnt #(.W(DAY_W), .MAX(DAY_M)) u_day (
        .clk(clk), .rst(rst), .en(en_day), .clr(clr), .ld(apply),
        .ld_val(ld_q.day), .cnt(day), .term(day_term), .co(week_co)
    );

endmodule
